// File: rtl/adc_pkg.sv
// adc_pkg: shared sample width and capture-FSM state encoding
package adc_pkg;
  localparam int SAMPLE_W = 12;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/adc_capture_buffer_if.sv
// adc_capture_buffer_if: sample input, trigger control and readout handshake bundle
interface adc_capture_buffer_if;
  import adc_pkg::*;
  logic [SAMPLE_W-1:0] sample_in;
  logic [SAMPLE_W-1:0] trig_level;
  logic [SAMPLE_W-1:0] rd_data;
  logic sample_valid;
  logic arm;
  logic rd_en;
  logic rd_valid;
  logic busy;
  logic triggered;
  logic done;
  modport master (
    output sample_in, sample_valid, arm, trig_level, rd_en,
    input  rd_data, rd_valid, busy, triggered, done
  );
  modport slave (
    input  sample_in, sample_valid, arm, trig_level, rd_en,
    output rd_data, rd_valid, busy, triggered, done
  );
endinterface

// File: rtl/adc_sample_ram.sv
// adc_sample_ram: simple dual-port sample store with registered read data
module adc_sample_ram
  import adc_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [SAMPLE_W-1:0] rdata
);
  logic [SAMPLE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: circular pre/post-trigger sample capture with oldest-first readout
module adc_capture_buffer
  import adc_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int PRE    = 64
) (
  input logic clk,
  input logic rst,
  adc_capture_buffer_if.slave bus
);
  localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE);
  localparam logic [ADDR_W-1:0] POST_N = ADDR_W'(DEPTH - PRE - 1);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, start_ptr, cnt;
  logic [SAMPLE_W-1:0] prev;
  logic trig_q, rv_q, wr, hit, rd_acc;
  assign wr     = bus.sample_valid && !bus.arm && (state inside {PREFILL, ARMED, POST});
  assign hit    = wr && state == ARMED && prev < bus.trig_level && bus.sample_in >= bus.trig_level;
  assign rd_acc = bus.rd_en && !bus.arm && state == DONE;
  always_comb begin
    nxt = bus.arm           ? (PRE == 0 ? ARMED : PREFILL)
        : state == PREFILL  ? (wr && cnt == PRE_A - 1'b1 ? ARMED : PREFILL)
        : state == ARMED    ? (hit ? (POST_N == '0 ? DONE : POST) : ARMED)
        : state == POST     ? (wr && cnt == ADDR_W'(1) ? DONE : POST)
        : state == DONE     ? (rd_acc && cnt == LAST ? IDLE : DONE)
        : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      start_ptr <= '0;
      cnt       <= '0;
      prev      <= '1;
      trig_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state <= nxt;
      rv_q  <= rd_acc;
      if (bus.arm) begin
        wr_ptr <= '0;
        cnt    <= '0;
        prev   <= '1;
        trig_q <= 1'b0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (wr && state == PREFILL) begin
          cnt  <= cnt + 1'b1;
          prev <= bus.sample_in;
        end
        if (hit) begin
          trig_q    <= 1'b1;
          start_ptr <= wr_ptr - PRE_A;
          cnt       <= POST_N;
        end else if (wr && state == ARMED) begin
          prev <= bus.sample_in;
        end
        if (wr && state == POST) cnt <= cnt - 1'b1;
        if (nxt == DONE && state != DONE) begin
          rd_ptr <= state == ARMED ? wr_ptr - PRE_A : start_ptr;
          cnt    <= '0;
        end
        if (rd_acc) begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end
  adc_sample_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (bus.sample_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );
  assign bus.rd_valid  = rv_q;
  assign bus.busy      = state inside {PREFILL, ARMED, POST};
  assign bus.triggered = trig_q;
  assign bus.done      = state == DONE;
endmodule
